// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer write path.
//  - Default visible resolution (640x480).
//  - fb_coord_t: 11-bit pixel coordinate, wide enough for either axis.
//  - fb_sched_state_t: write scheduler state (serving clients or sweeping a clear).
//  - fb_in_range(): true when a coordinate pair lies inside the visible area.
package fb_pkg;

  localparam int FB_HRES = 640;
  localparam int FB_VRES = 480;

  typedef logic [10:0] fb_coord_t;

  typedef enum logic {
    SERVE = 1'b0,
    CLEAR = 1'b1
  } fb_sched_state_t;

  // Coordinates are compared against the last valid index rather than the
  // resolution itself, so a resolution of exactly 2048 cannot wrap the bound.
  function automatic logic fb_in_range(input fb_coord_t x, input fb_coord_t y,
                                       input fb_coord_t x_last, input fb_coord_t y_last);
    return (x <= x_last) && (y <= y_last);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a combinational grant.
// Ports:
//  clk, rst   clock and synchronous active-high reset
//  req[1:0]   request vector (bit 0 = client A, bit 1 = client B)
//  en         arbitration enable; no grant is issued while low
//  gnt[1:0]   one-hot (or zero) grant, valid in the same cycle as req
// After reset the last grant is taken to be B, so A wins the first tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // 1 = client B was granted most recently.
  logic last_b_reg;

  always_comb begin
    gnt    = 2'b00;
    gnt[0] = en & req[0] & (~req[1] | last_b_reg);
    gnt[1] = en & req[1] & (~req[0] | ~last_b_reg);
  end

  // Only an actual grant moves the priority pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_b_reg <= 1'b1;
    end else if (en && (|gnt)) begin
      last_b_reg <= gnt[1];
    end
  end

endmodule

// File: rtl/fb_write_scheduler.sv
// Owner of the framebuffer's single pixel write port.
// Shares the port between drawing clients A and B (round-robin) and performs a
// full-screen clear of the back buffer, started on the frame_start pulse that
// follows a clear request.
// Ports:
//  clk, rst               clock and synchronous active-high reset
//  frame_start            one-cycle start-of-frame / buffer-swap pulse
//  clear_req              one-cycle pulse requesting a clear at the next frame_start
//  a_valid/a_x/a_y/a_color, a_ready   client A pixel handshake (ready is combinational)
//  b_valid/b_x/b_y/b_color, b_ready   client B pixel handshake
//  fb_x, fb_y, fb_color, fb_write     registered write command to the framebuffer
//  busy                   high while the clear sweep is running
//  clear_done             one-cycle pulse in the cycle after the last clear write is issued
module fb_write_scheduler
  import fb_pkg::*;
#(
  parameter int   HRES        = FB_HRES,
  parameter int   VRES        = FB_VRES,
  parameter logic CLEAR_COLOR = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      frame_start,
  input  logic      clear_req,
  input  logic      a_valid,
  input  fb_coord_t a_x,
  input  fb_coord_t a_y,
  input  logic      a_color,
  output logic      a_ready,
  input  logic      b_valid,
  input  fb_coord_t b_x,
  input  fb_coord_t b_y,
  input  logic      b_color,
  output logic      b_ready,
  output fb_coord_t fb_x,
  output fb_coord_t fb_y,
  output logic      fb_color,
  output logic      fb_write,
  output logic      busy,
  output logic      clear_done
);

  localparam fb_coord_t X_LAST = fb_coord_t'(HRES - 1);
  localparam fb_coord_t Y_LAST = fb_coord_t'(VRES - 1);

  fb_sched_state_t state_reg;
  logic            clear_pending_reg;
  fb_coord_t       cx_reg;
  fb_coord_t       cy_reg;
  fb_coord_t       fb_x_reg;
  fb_coord_t       fb_y_reg;
  logic            fb_color_reg;
  logic            fb_write_reg;
  logic            clear_done_reg;

  logic [1:0] gnt;
  logic       xfer;
  fb_coord_t  sel_x;
  fb_coord_t  sel_y;
  logic       sel_color;
  logic       start_clear;

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({b_valid, a_valid}),
    .en  (state_reg == SERVE),
    .gnt (gnt)
  );

  assign a_ready = gnt[0];
  assign b_ready = gnt[1];
  assign xfer    = |gnt;

  always_comb begin
    sel_x     = a_x;
    sel_y     = a_y;
    sel_color = a_color;
    if (gnt[1]) begin
      sel_x     = b_x;
      sel_y     = b_y;
      sel_color = b_color;
    end
  end

  // A request arriving in the same cycle as frame_start starts the clear directly.
  assign start_clear = frame_start & (clear_pending_reg | clear_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= SERVE;
      clear_pending_reg <= 1'b0;
      cx_reg            <= '0;
      cy_reg            <= '0;
      fb_x_reg          <= '0;
      fb_y_reg          <= '0;
      fb_color_reg      <= 1'b0;
      fb_write_reg      <= 1'b0;
      clear_done_reg    <= 1'b0;
    end else begin
      fb_write_reg   <= 1'b0;
      clear_done_reg <= 1'b0;
      case (state_reg)
        SERVE: begin
          // Off-screen pixels are consumed (ready stays high) but never written;
          // the framebuffer outputs keep their last written values.
          if (xfer && fb_in_range(sel_x, sel_y, X_LAST, Y_LAST)) begin
            fb_x_reg     <= sel_x;
            fb_y_reg     <= sel_y;
            fb_color_reg <= sel_color;
            fb_write_reg <= 1'b1;
          end
          if (start_clear) begin
            state_reg         <= CLEAR;
            clear_pending_reg <= 1'b0;
            cx_reg            <= '0;
            cy_reg            <= '0;
          end else if (clear_req) begin
            clear_pending_reg <= 1'b1;
          end
        end
        CLEAR: begin
          fb_x_reg     <= cx_reg;
          fb_y_reg     <= cy_reg;
          fb_color_reg <= CLEAR_COLOR;
          fb_write_reg <= 1'b1;
          // frame_start is ignored here; a new request is queued for the next frame.
          if (clear_req) begin
            clear_pending_reg <= 1'b1;
          end
          if (cx_reg == X_LAST) begin
            cx_reg <= '0;
            if (cy_reg == Y_LAST) begin
              cy_reg         <= '0;
              state_reg      <= SERVE;
              clear_done_reg <= 1'b1;
            end else begin
              cy_reg <= cy_reg + 11'd1;
            end
          end else begin
            cx_reg <= cx_reg + 11'd1;
          end
        end
        default: state_reg <= SERVE;
      endcase
    end
  end

  assign fb_x       = fb_x_reg;
  assign fb_y       = fb_y_reg;
  assign fb_color   = fb_color_reg;
  assign fb_write   = fb_write_reg;
  assign clear_done = clear_done_reg;
  assign busy       = (state_reg == CLEAR);

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed bench for fb_write_scheduler, run with a reduced 20x12 screen so a
// clear sweep is 240 writes.
module tb_fb_write_scheduler;
  import fb_pkg::*;

  localparam int HRES = 20;
  localparam int VRES = 12;
  localparam int NPIX = HRES * VRES;

  logic      clk = 1'b0;
  logic      rst;
  logic      frame_start;
  logic      clear_req;
  logic      a_valid, b_valid;
  fb_coord_t a_x, a_y, b_x, b_y;
  logic      a_color, b_color;
  logic      a_ready, b_ready;
  fb_coord_t fb_x, fb_y;
  logic      fb_color, fb_write, busy, clear_done;

  int tests_run = 0;
  int tests_failed = 0;

  fb_write_scheduler #(.HRES(HRES), .VRES(VRES), .CLEAR_COLOR(1'b0)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .clear_req(clear_req),
    .a_valid(a_valid), .a_x(a_x), .a_y(a_y), .a_color(a_color), .a_ready(a_ready),
    .b_valid(b_valid), .b_x(b_x), .b_y(b_y), .b_color(b_color), .b_ready(b_ready),
    .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .fb_write(fb_write),
    .busy(busy), .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packs the registered write command with busy/clear_done for one-line checks.
  function automatic logic [31:0] pack(input logic w, input logic c, input fb_coord_t x,
                                       input fb_coord_t y, input logic bz, input logic cd);
    return {6'd0, w, c, x, y, bz, cd};
  endfunction

  function automatic logic [31:0] obs_pack();
    return pack(fb_write, fb_color, fb_x, fb_y, busy, clear_done);
  endfunction

  // Expected output after the k-th tick of a clear sweep (k = 0 shows pixel (0,0)).
  function automatic logic [31:0] clr_exp(input int k);
    return pack(1'b1, 1'b0, fb_coord_t'(k % HRES), fb_coord_t'(k / HRES),
                (k != NPIX - 1), (k == NPIX - 1));
  endfunction

  initial begin
    rst = 1'b1; frame_start = 1'b0; clear_req = 1'b0;
    a_valid = 1'b0; a_x = '0; a_y = '0; a_color = 1'b0;
    b_valid = 1'b0; b_x = '0; b_y = '0; b_color = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("reset_outs", obs_pack(), pack(1'b0, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0));
    chk("reset_ready", {30'd0, a_ready, b_ready}, 32'd0);
    $display("[TB] reset checked");

    // 1: A alone, latency 1
    a_valid = 1'b1; a_x = 11'd10; a_y = 11'd11; a_color = 1'b1;
    #1;
    chk("t1_ready", {30'd0, a_ready, b_ready}, 32'b10);
    tick();
    a_valid = 1'b0;
    chk("t1_write", obs_pack(), pack(1'b1, 1'b1, 11'd10, 11'd11, 1'b0, 1'b0));
    tick();
    chk("t1_idle", obs_pack(), pack(1'b0, 1'b1, 11'd10, 11'd11, 1'b0, 1'b0));
    $display("[TB] single pixel A (10,11,1)");

    // 2: both valid, A won last so grants go B,A,B,A
    a_valid = 1'b1; a_x = 11'd1; a_y = 11'd2; a_color = 1'b0;
    b_valid = 1'b1; b_x = 11'd3; b_y = 11'd4; b_color = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_gnt", {30'd0, a_ready, b_ready}, (i % 2 == 0) ? 32'b01 : 32'b10);
      tick();
      if (i % 2 == 0)
        chk("t2_write", obs_pack(), pack(1'b1, 1'b1, 11'd3, 11'd4, 1'b0, 1'b0));
      else
        chk("t2_write", obs_pack(), pack(1'b1, 1'b0, 11'd1, 11'd2, 1'b0, 1'b0));
      $display("[TB] contention cycle %0d", i);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    chk("t2_idle_we", {31'd0, fb_write}, 32'd0);

    // 3: out-of-range accepted but not written, edge pixel written
    a_valid = 1'b1; a_x = 11'd20; a_y = 11'd5; a_color = 1'b1;
    #1;
    chk("t3_oor_ready", {31'd0, a_ready}, 32'd1);
    tick();
    a_x = 11'd3; a_y = 11'd12;
    chk("t3_oor_x_we", {31'd0, fb_write}, 32'd0);
    tick();
    a_x = 11'd19; a_y = 11'd11; a_color = 1'b0;
    chk("t3_oor_y_we", {31'd0, fb_write}, 32'd0);
    #1;
    chk("t3_edge_ready", {31'd0, a_ready}, 32'd1);
    tick();
    a_valid = 1'b0;
    chk("t3_edge_write", obs_pack(), pack(1'b1, 1'b0, 11'd19, 11'd11, 1'b0, 1'b0));
    $display("[TB] out-of-range (20,5),(3,12) dropped, (19,11) written");

    // 4: clear_req, frame_start later; B waits across the clear
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("t4_wait_busy", {31'd0, busy}, 32'd0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    b_valid = 1'b1; b_x = 11'd7; b_y = 11'd8; b_color = 1'b1;
    #1;
    chk("t4_enter", {29'd0, busy, fb_write, b_ready}, 32'b100);
    for (int k = 0; k < NPIX; k++) begin
      tick();
      chk("t4_clear_px", obs_pack(), clr_exp(k));
      chk("t4_b_ready", {31'd0, b_ready}, (k == NPIX - 1) ? 32'd1 : 32'd0);
    end
    tick();
    b_valid = 1'b0;
    chk("t4_b_after", obs_pack(), pack(1'b1, 1'b1, 11'd7, 11'd8, 1'b0, 1'b0));
    $display("[TB] clear of %0d pixels, then B (7,8,1)", NPIX);

    // 5: clear_req with frame_start; mid-clear clear_req and frame_start
    clear_req = 1'b1; frame_start = 1'b1;
    tick();
    clear_req = 1'b0; frame_start = 1'b0;
    chk("t5_enter_busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < NPIX; k++) begin
      clear_req   = (k == 5);
      frame_start = (k == 10);
      tick();
      chk("t5_clear_px", obs_pack(), clr_exp(k));
    end
    clear_req = 1'b0; frame_start = 1'b0;
    tick();
    chk("t5_serve", {30'd0, busy, clear_done}, 32'd0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("t5_second_busy", {31'd0, busy}, 32'd1);
    $display("[TB] clear with same-cycle request, no restart, second clear queued");

    // 6: reset during the second clear
    for (int k = 0; k < 100; k++) begin
      tick();
      chk("t6_clear_px", obs_pack(), clr_exp(k));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_after_rst", obs_pack(), pack(1'b0, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0));
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("t6_no_pending", {31'd0, busy}, 32'd0);
    a_valid = 1'b1; a_x = 11'd5; a_y = 11'd6; a_color = 1'b1;
    b_valid = 1'b1; b_x = 11'd9; b_y = 11'd9; b_color = 1'b0;
    #1;
    chk("t6_ready", {30'd0, a_ready, b_ready}, 32'b10);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("t6_write", obs_pack(), pack(1'b1, 1'b1, 11'd5, 11'd6, 1'b0, 1'b0));
    $display("[TB] reset mid-clear, then A (5,6,1)");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
